// File: rtl/stft_frame_ctrl.sv
// STFT framing controller: writes samples into a circular buffer and reads
// overlapping windows of WIN_LEN samples, zero-padded to N_FFT, one frame per fft_rdy grant.
module stft_frame_ctrl #(
  parameter int N_FFT   = 512,
  parameter int WIN_LEN = 480,
  parameter int HOP_LEN = 160,
  localparam int BUF_DEPTH = 2 ** $clog2(WIN_LEN),
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int IW        = $clog2(N_FFT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          den,
  input  logic          fft_rdy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [IW-1:0] win_idx,
  output logic          pad,
  output logic          frm_start,
  output logic          frm_last,
  output logic [AW:0]   buf_count,
  output logic          ovf,
  output logic [15:0]   frm_cnt,
  output logic [1:0]    state_dbg
);

  // Handshake: den is a one-cycle sample strobe with no back-pressure (dropped
  // when full); fft_rdy is sampled only in IDLE and grants one whole frame.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(BUF_DEPTH);
  localparam logic [AW:0]   WIN_C    = (AW + 1)'(WIN_LEN);
  localparam logic [AW:0]   HOP_C    = (AW + 1)'(HOP_LEN);
  localparam logic [AW-1:0] HOP_A    = AW'(HOP_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_FFT - 1);
  localparam logic [IW:0]   WIN_IDX  = (IW + 1)'(WIN_LEN);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] base_ptr, base_nxt;
  logic [AW-1:0] rd_addr_nxt;
  logic [IW-1:0] win_idx_nxt, idx;
  logic          rd_en_nxt, pad_nxt, frm_start_nxt, frm_last_nxt, ovf_nxt;
  logic [AW:0]   buf_count_nxt;
  logic [15:0]   frm_cnt_nxt;
  logic          frame_end, load;

  assign wr_en     = den && (buf_count < DEPTH_C);
  assign wr_addr   = wr_ptr;
  assign state_dbg = state;

  always_comb begin
    state_nxt     = state;
    win_idx_nxt   = '0;
    rd_en_nxt     = 1'b0;
    pad_nxt       = 1'b0;
    frm_start_nxt = 1'b0;
    frm_last_nxt  = 1'b0;
    rd_addr_nxt   = rd_addr;
    base_nxt      = base_ptr;
    frm_cnt_nxt   = frm_cnt;
    frame_end     = 1'b0;
    load          = 1'b0;
    idx           = '0;
    case (state)
      IDLE: begin
        if (buf_count >= WIN_C && fft_rdy) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (win_idx == LAST_IDX) begin
          frame_end   = 1'b1;
          state_nxt   = GAP;
          base_nxt    = base_ptr + HOP_A;
          frm_cnt_nxt = frm_cnt + 16'd1;
        end else begin
          load = 1'b1;
          idx  = win_idx + 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Outputs are registered, so they are computed for the index entered next cycle.
    if (load) begin
      win_idx_nxt   = idx;
      frm_start_nxt = (idx == '0);
      frm_last_nxt  = (idx == LAST_IDX);
      if ({1'b0, idx} < WIN_IDX) begin
        rd_en_nxt   = 1'b1;
        rd_addr_nxt = base_ptr + AW'(idx);
      end else begin
        pad_nxt = 1'b1;
      end
    end
    buf_count_nxt = buf_count + {{AW{1'b0}}, wr_en} - (frame_end ? HOP_C : '0);
    ovf_nxt       = ovf | (den && (buf_count == DEPTH_C));
    wr_ptr_nxt    = wr_en ? wr_ptr + 1'b1 : wr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      base_ptr  <= '0;
      win_idx   <= '0;
      buf_count <= '0;
      frm_cnt   <= '0;
      ovf       <= 1'b0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      pad       <= 1'b0;
      frm_start <= 1'b0;
      frm_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      base_ptr  <= base_nxt;
      win_idx   <= win_idx_nxt;
      buf_count <= buf_count_nxt;
      frm_cnt   <= frm_cnt_nxt;
      ovf       <= ovf_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_en     <= rd_en_nxt;
      pad       <= pad_nxt;
      frm_start <= frm_start_nxt;
      frm_last  <= frm_last_nxt;
    end
  end

endmodule

// File: tb/tb_stft_frame_ctrl.sv
// Bench for stft_frame_ctrl: table of idle/fill/overflow steps, then frame
// sequences whose read addresses are checked against an expected-address queue.
module tb_stft_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        den;
  logic        fft_rdy;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [8:0]  win_idx;
  logic        pad;
  logic        frm_start;
  logic        frm_last;
  logic [9:0]  buf_count;
  logic        ovf;
  logic [15:0] frm_cnt;
  logic [1:0]  state_dbg;

  stft_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .den       (den),
    .fft_rdy   (fft_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .win_idx   (win_idx),
    .pad       (pad),
    .frm_start (frm_start),
    .frm_last  (frm_last),
    .buf_count (buf_count),
    .ovf       (ovf),
    .frm_cnt   (frm_cnt),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit rst;
    bit den;
    bit rdy;
    int n;
    bit exp_wr;
    int exp_cnt;
    bit exp_ovf;
    int exp_state;
    int exp_wa;
  } step_t;

  step_t      steps[10];
  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_cnt = 0;
  int         exp_frm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; asserts reset and checks the asynchronous clear.
  task automatic do_reset();
    rst_n   = 1'b0;
    den     = 1'b0;
    fft_rdy = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_win_idx", win_idx, 0);
    chk("rst_pad", pad, 0);
    chk("rst_frm_start", frm_start, 0);
    chk("rst_frm_last", frm_last, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_frm_cnt", frm_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    exp_frm = 0;
  endtask

  task automatic apply_step(input step_t s);
    if (s.rst) do_reset();
    den     = s.den;
    fft_rdy = s.rdy;
    for (int c = 0; c < s.n; c++) begin
      @(negedge clk);
      chk("idle_frm_start", frm_start, 0);
    end
    #1;
    chk("step_wr_en", wr_en, s.exp_wr);
    chk("step_buf_count", buf_count, s.exp_cnt);
    chk("step_ovf", ovf, s.exp_ovf);
    chk("step_state", state_dbg, s.exp_state);
    chk("step_wr_addr", wr_addr, s.exp_wa);
  endtask

  task automatic feed(input int n);
    den = 1'b1;
    repeat (n) @(negedge clk);
    den = 1'b0;
    exp_cnt += n;
  endtask

  task automatic run_frame(input int base, input bit wr_end, input int abort_at);
    logic [8:0] e;
    chk("pre_buf_count", buf_count, exp_cnt);
    exp_q.delete();
    for (int j = 0; j < 480; j++) exp_q.push_back(9'((base + j) % 512));
    fft_rdy = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      fft_rdy = 1'b0;
      chk("run_state", state_dbg, 1);
      chk("win_idx", win_idx, i);
      chk("frm_start", frm_start, (i == 0));
      chk("frm_last", frm_last, (i == 511));
      chk("pad", pad, (i >= 480));
      chk("rd_en", rd_en, (i < 480));
      if (rd_en) begin
        if (exp_q.size() == 0) begin
          chk("rd_en_extra", rd_en, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", rd_addr, e);
        end
      end
      if (i >= 480) chk("rd_addr_hold", rd_addr, (base + 479) % 512);
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (i == 511 && wr_end) den = 1'b1;
    end
    exp_frm++;
    exp_cnt = exp_cnt + int'(wr_end) - 160;
    @(negedge clk);
    den = 1'b0;
    chk("gap_state", state_dbg, 2);
    chk("gap_frm_cnt", frm_cnt, exp_frm);
    chk("gap_buf_count", buf_count, exp_cnt);
    chk("gap_rd_en", rd_en, 0);
    chk("gap_pad", pad, 0);
    chk("gap_win_idx", win_idx, 0);
    chk("gap_frm_last", frm_last, 0);
    @(negedge clk);
    chk("post_state", state_dbg, 0);
    chk("post_buf_count", buf_count, exp_cnt);
    chk("q_drained", exp_q.size(), 0);
  endtask

  initial begin
    //           rst den rdy n    wr cnt  ovf st wa
    steps[0] = '{1, 0, 0, 0,   0, 0,   0, 0, 0};
    steps[1] = '{0, 1, 0, 0,   1, 0,   0, 0, 0};
    steps[2] = '{0, 1, 0, 480, 1, 480, 0, 0, 480};
    steps[3] = '{0, 0, 0, 100, 0, 480, 0, 0, 480};
    steps[4] = '{0, 1, 0, 32,  0, 512, 0, 0, 0};
    steps[5] = '{0, 1, 0, 1,   0, 512, 1, 0, 0};
    steps[6] = '{1, 1, 0, 512, 0, 512, 0, 0, 0};
    steps[7] = '{0, 1, 0, 1,   0, 512, 1, 0, 0};
    steps[8] = '{0, 1, 0, 87,  0, 512, 1, 0, 0};
    steps[9] = '{0, 0, 0, 3,   0, 512, 1, 0, 0};

    rst_n   = 1'b0;
    den     = 1'b0;
    fft_rdy = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 10; k++) apply_step(steps[k]);
    den     = 1'b0;
    fft_rdy = 1'b0;

    // Back-to-back frames: wrap through 511->0, write on the frame-end edge.
    @(negedge clk);
    do_reset();
    feed(480);
    run_frame(0, 1'b0, -1);
    feed(160);
    run_frame(160, 1'b1, -1);
    feed(159);
    run_frame(320, 1'b0, -1);
    chk("final_wr_addr", wr_addr, 288);

    // Reset mid-frame, then the next frame must start from address 0.
    do_reset();
    feed(480);
    run_frame(0, 1'b0, 200);
    feed(480);
    run_frame(0, 1'b0, -1);
    chk("abort_frm_cnt", frm_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stft_frame_ctrl.md
STFT_FRAME_CTRL -- requirements
Module: stft_frame_ctrl

Interface
REQ-001 Parameter: N_FFT, 512, frame length delivered to FFT (window samples plus zero pad).
REQ-002 Parameter: WIN_LEN, 480, window length in samples; SHALL satisfy WIN_LEN <= N_FFT.
REQ-003 Parameter: HOP_LEN, 160, frame advance in samples; SHALL satisfy 0 < HOP_LEN <= WIN_LEN.
REQ-004 Derived: BUF_DEPTH = 2**clog2(WIN_LEN) (512); AW = clog2(BUF_DEPTH) (9); IW = clog2(N_FFT) (9).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 den  input  1  input sample valid, one sample per asserted cycle.
REQ-008 fft_rdy  input  1  downstream can accept a complete frame.
REQ-009 wr_en  output  1  write strobe to circular buffer.
REQ-010 wr_addr  output  AW  buffer write address.
REQ-011 rd_en  output  1  buffer read strobe.
REQ-012 rd_addr  output  AW  buffer read address.
REQ-013 win_idx  output  IW  window LUT index / position in frame.
REQ-014 pad  output  1  zero-pad cycle.
REQ-015 frm_start, frm_last  output  1 each  first / last cycle of frame.
REQ-016 buf_count  output  AW+1  samples held, not yet released.
REQ-017 ovf  output  1  sticky overflow flag.
REQ-018 frm_cnt  output  16  frames completed, wraps at 2**16.

Function
REQ-019 wr_en SHALL be combinational: den && (buf_count < BUF_DEPTH); wr_addr = wr_ptr (registered).
REQ-020 On each wr_en, wr_ptr SHALL increment modulo BUF_DEPTH.
REQ-021 den while buf_count == BUF_DEPTH: sample dropped, wr_en=0, ovf set until reset.
REQ-022 FSM states: IDLE, RUN, GAP; all outputs except wr_en registered.
REQ-023 IDLE -> RUN on edge where buf_count >= WIN_LEN && fft_rdy; else stay IDLE.
REQ-024 RUN lasts exactly N_FFT cycles; win_idx = 0..N_FFT-1, incrementing by 1 per cycle; fft_rdy ignored in RUN.
REQ-025 RUN, win_idx < WIN_LEN: rd_en=1, pad=0, rd_addr = (base_ptr + win_idx) mod BUF_DEPTH.
REQ-026 RUN, win_idx >= WIN_LEN: rd_en=0, pad=1, rd_addr held at last value.
REQ-027 frm_start=1 only when win_idx==0 in RUN; frm_last=1 only when win_idx==N_FFT-1 in RUN.
REQ-028 Frame end (edge leaving frm_last cycle): base_ptr += HOP_LEN mod BUF_DEPTH; frm_cnt += 1; state -> GAP.
REQ-029 GAP lasts exactly 1 cycle, then IDLE; guarantees >= 1 idle cycle between frames.
REQ-030 buf_count next = buf_count + wr_en - (HOP_LEN at frame end); simultaneous write and release both applied same edge.
REQ-031 Outside RUN: rd_en=0, pad=0, frm_start=0, frm_last=0, win_idx=0.
REQ-032 Writes SHALL never target addresses base_ptr..base_ptr+buf_count-1 mod BUF_DEPTH (guaranteed by REQ-019).

Reset
REQ-033 rst_n low SHALL immediately clear: state=IDLE, wr_ptr, base_ptr, win_idx, buf_count, frm_cnt, ovf, rd_addr = 0; rd_en, pad, frm_start, frm_last = 0.
REQ-034 Reset mid-RUN SHALL abort the frame with no base_ptr advance; first frame after release starts at address 0.

Verification
REQ-035 Reset, den=1 for 480 cycles, fft_rdy=1 -> buf_count=480, frm_start 1 cycle later, rd_addr 0..479, pad for win_idx 480..511, frm_last at win_idx 511, buf_count 320, frm_cnt 1.
REQ-036 After REQ-035, 160 more samples -> second frame rd_addr 160..127 wrapping through 511->0, base_ptr 320 afterwards, frm_cnt 2.
REQ-037 buf_count=480, fft_rdy=0 for 100 cycles -> no frm_start; fft_rdy=1 -> frm_start next cycle.
REQ-038 den=1 continuous 600 cycles, fft_rdy=0 -> buf_count saturates at 512, wr_en 0 from sample 513, ovf=1 and stays 1.
REQ-039 Write on exact frame-end edge with buf_count=480 -> buf_count 321; GAP one cycle; IDLE holds with 321.
REQ-040 rst_n pulsed low at win_idx 200 -> all outputs 0 asynchronously; after release 480 samples produce frame starting rd_addr 0.
